// File: rtl/pong_ctrl.sv
// pong_ctrl: frame-rate sequencer for pong (ball and paddle motion, collisions, scoring, serve timing).
// Latency: game state updates on the clk edge that ends the frame-tick cycle; a start edge is acted on one cycle after it.
// Backpressure: none; inputs are sampled every cycle and all outputs are registered and held between ticks.
// Optional feature: define PONG_AI_EN to let the right paddle track the ball instead of its buttons.
module pong_ctrl #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_XL    = 16,
  parameter int PADDLE_XR    = 616,
  parameter int PADDLE_STEP  = 4,
  parameter int BALL_STEP    = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       start,
  input  logic       btn_l_up,
  input  logic       btn_l_dn,
  input  logic       btn_r_up,
  input  logic       btn_r_dn,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] pad_l_y,
  output logic [9:0] pad_r_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] state,
  output logic       game_over
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_PLAY  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  // Geometry, all derived from the screen and object sizes.
  localparam logic [9:0]         BALL_CX = 10'(H_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [9:0]         BALL_CY = 10'(V_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [9:0]         PAD_C   = 10'(V_ACTIVE / 2 - PADDLE_H / 2);
  localparam logic [9:0]         PAD_MAX = 10'(V_ACTIVE - PADDLE_H);
  localparam logic signed [10:0] Y_MAX   = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic signed [10:0] X_MAX   = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic signed [10:0] XL_HIT  = 11'(PADDLE_XL + PADDLE_W);
  localparam logic signed [10:0] XR_HIT  = 11'(PADDLE_XR - BALL_SIZE);
  localparam logic signed [10:0] VSTEP   = 11'(BALL_STEP);
  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES);

  // Registered state
  state_t             st_q, st_d;
  logic [9:0]         ball_x_q, ball_x_d;
  logic [9:0]         ball_y_q, ball_y_d;
  logic signed [10:0] vx_q, vx_d;
  logic signed [10:0] vy_q, vy_d;
  logic [9:0]         pad_l_q, pad_l_d;
  logic [9:0]         pad_r_q, pad_r_d;
  logic [3:0]         score_l_q, score_l_d;
  logic [3:0]         score_r_q, score_r_d;
  logic [CNT_W-1:0]   serve_cnt_q, serve_cnt_d;
  logic               serve_pos_q, serve_pos_d;  // 1: serve toward +x
  logic               start_q;
  logic               game_over_q;

  // Decoded events
  logic tick;
  logic start_rise;

  // Paddle candidates for this tick
  logic       r_up, r_dn;
  logic [9:0] pad_l_nx, pad_r_nx;

  // Ball datapath
  logic signed [10:0] bx_s, next_x, next_y, vx_nx, vy_nx;
  logic [9:0]         nx_fin, ny_fin;
  logic               overlap_l, overlap_r, hit_l, hit_r, miss_l, miss_r;

  assign tick       = (hcount == 10'd0) && (vcount == 10'(V_ACTIVE));
  assign start_rise = start && !start_q;

  // One paddle step with saturation at the top and bottom of the screen; both or neither pressed holds.
  function automatic logic [9:0] pad_move(input logic [9:0] y, input logic up, input logic dn);
    logic [9:0]  r;
    logic [10:0] lowered;
    r       = y;
    lowered = {1'b0, y} + 11'(PADDLE_STEP);
    if (up && !dn) begin
      r = (y >= 10'(PADDLE_STEP)) ? (y - 10'(PADDLE_STEP)) : 10'd0;
    end else if (dn && !up) begin
      r = (lowered >= {1'b0, PAD_MAX}) ? PAD_MAX : lowered[9:0];
    end
    return r;
  endfunction

`ifdef PONG_AI_EN
  localparam logic signed [11:0] AI_STEP = 12'(PADDLE_STEP);
  logic signed [11:0] ai_diff;
  logic               unused_btn_r;

  assign unused_btn_r = btn_r_up ^ btn_r_dn;

  // Right paddle chases the ball centre; the one-step dead band stops it dithering around alignment.
  always_comb begin
    ai_diff = $signed({2'b00, ball_y_q}) + $signed(12'(BALL_SIZE / 2))
            - $signed({2'b00, pad_r_q}) - $signed(12'(PADDLE_H / 2));
    r_up    = (ai_diff <= -AI_STEP);
    r_dn    = (ai_diff >= AI_STEP);
  end
`else
  assign r_up = btn_r_up;
  assign r_dn = btn_r_dn;
`endif

  assign pad_l_nx = pad_move(pad_l_q, btn_l_up, btn_l_dn);
  assign pad_r_nx = pad_move(pad_r_q, r_up, r_dn);

  // Ball step for one frame: wall bounce on y, paddle bounce or miss on x, evaluated against current positions.
  always_comb begin
    bx_s   = $signed({1'b0, ball_x_q});
    next_x = bx_s + vx_q;
    next_y = $signed({1'b0, ball_y_q}) + vy_q;

    vy_nx  = vy_q;
    ny_fin = next_y[9:0];
    if (next_y <= 11'sd0) begin
      ny_fin = 10'd0;
      vy_nx  = VSTEP;
    end else if (next_y >= Y_MAX) begin
      ny_fin = Y_MAX[9:0];
      vy_nx  = -VSTEP;
    end

    overlap_l = (({1'b0, ball_y_q} + 11'(BALL_SIZE)) > {1'b0, pad_l_q}) &&
                ({1'b0, ball_y_q} < ({1'b0, pad_l_q} + 11'(PADDLE_H)));
    overlap_r = (({1'b0, ball_y_q} + 11'(BALL_SIZE)) > {1'b0, pad_r_q}) &&
                ({1'b0, ball_y_q} < ({1'b0, pad_r_q} + 11'(PADDLE_H)));

    // Requiring the ball to start on the court side of the paddle face stops a ball
    // that already slipped past from being caught from behind.
    hit_l = (vx_q < 11'sd0) && (next_x <= XL_HIT) && (bx_s >= XL_HIT) && overlap_l;
    hit_r = (vx_q > 11'sd0) && (next_x >= XR_HIT) && (bx_s <= XR_HIT) && overlap_r;

    miss_l = !hit_l && !hit_r && (next_x <= 11'sd0);
    miss_r = !hit_l && !hit_r && !miss_l && (next_x >= X_MAX);

    vx_nx  = vx_q;
    nx_fin = next_x[9:0];
    if (hit_l) begin
      nx_fin = XL_HIT[9:0];
      vx_nx  = VSTEP;
    end else if (hit_r) begin
      nx_fin = XR_HIT[9:0];
      vx_nx  = -VSTEP;
    end
  end

  // Game sequencing: start edges act immediately, everything else waits for the frame tick.
  always_comb begin
    st_d        = st_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    pad_l_d     = pad_l_q;
    pad_r_d     = pad_r_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    serve_cnt_d = serve_cnt_q;
    serve_pos_d = serve_pos_q;

    case (st_q)
      S_IDLE, S_OVER: begin
        if (start_rise) begin
          st_d        = S_SERVE;
          score_l_d   = 4'd0;
          score_r_d   = 4'd0;
          serve_pos_d = 1'b1;
          serve_cnt_d = SERVE_LOAD;
        end
      end

      S_SERVE: begin
        if (tick) begin
          pad_l_d     = pad_l_nx;
          pad_r_d     = pad_r_nx;
          serve_cnt_d = serve_cnt_q - 1'b1;
          if (serve_cnt_d == '0) begin
            st_d = S_PLAY;
            vx_d = serve_pos_q ? VSTEP : -VSTEP;
            vy_d = VSTEP;
          end
        end
      end

      S_PLAY: begin
        if (tick) begin
          pad_l_d = pad_l_nx;
          pad_r_d = pad_r_nx;
          if (miss_l || miss_r) begin
            // Recentre and serve toward whoever conceded.
            if (miss_l) begin
              score_r_d   = score_r_q + 4'd1;
              serve_pos_d = 1'b0;
            end else begin
              score_l_d   = score_l_q + 4'd1;
              serve_pos_d = 1'b1;
            end
            ball_x_d    = BALL_CX;
            ball_y_d    = BALL_CY;
            vx_d        = 11'sd0;
            vy_d        = 11'sd0;
            serve_cnt_d = SERVE_LOAD;
            st_d        = ((score_l_d == 4'(WIN_SCORE)) || (score_r_d == 4'(WIN_SCORE)))
                          ? S_OVER : S_SERVE;
          end else begin
            ball_x_d = nx_fin;
            ball_y_d = ny_fin;
            vx_d     = vx_nx;
            vy_d     = vy_nx;
          end
        end
      end

      default: st_d = S_IDLE;
    endcase
  end

  // State register; reset restores the idle picture regardless of pending tick or start edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_q        <= S_IDLE;
      ball_x_q    <= BALL_CX;
      ball_y_q    <= BALL_CY;
      vx_q        <= 11'sd0;
      vy_q        <= 11'sd0;
      pad_l_q     <= PAD_C;
      pad_r_q     <= PAD_C;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      serve_cnt_q <= '0;
      serve_pos_q <= 1'b1;
      start_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      pad_l_q     <= pad_l_d;
      pad_r_q     <= pad_r_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      serve_cnt_q <= serve_cnt_d;
      serve_pos_q <= serve_pos_d;
      start_q     <= start;
      game_over_q <= (st_d == S_OVER);
    end
  end

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign pad_l_y   = pad_l_q;
  assign pad_r_y   = pad_r_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign state     = st_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_pong_ctrl.sv
// tb_pong_ctrl: drives frame ticks, buttons and start against pong_ctrl and compares every cycle with a game model.
// Latency: outputs sampled 1 time unit after each rising clk edge.
// Backpressure: not applicable.
module tb_pong_ctrl;

  // Game constants restated from the game rules.
  localparam int HA = 640, VA = 480, BS = 8, PH = 64;
  localparam int XL_FACE = 24, XR_FACE = 608;
  localparam int PSTEP = 4, BSTEP = 2, SERVE_N = 60, WIN = 9;
  localparam int BX0 = 316, BY0 = 236, PY0 = 208;
  localparam int M_NONE = 0, M_RAND = 1, M_SMART = 2, M_UP = 3, M_BOTH = 4;
  localparam logic [50:0] RST_VEC = {2'd0, 1'b0, 10'd316, 10'd236, 10'd208, 10'd208, 4'd0, 4'd0};

  logic       clk = 1'b0;
  logic       reset_n, start, btn_l_up, btn_l_dn, btn_r_up, btn_r_dn;
  logic [9:0] hcount, vcount, ball_x, ball_y, pad_l_y, pad_r_y;
  logic [3:0] score_l, score_r;
  logic [1:0] state;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  // Model state
  int m_state, m_bx, m_by, m_vx, m_vy, m_pl, m_pr, m_sl, m_sr, m_serve_ticks, m_dir;
  bit m_sp;
  int n_hits = 0, n_miss = 0, n_wall = 0;

  always #5 clk = ~clk;

  pong_ctrl dut (
    .clk(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount), .start(start),
    .btn_l_up(btn_l_up), .btn_l_dn(btn_l_dn), .btn_r_up(btn_r_up), .btn_r_dn(btn_r_dn),
    .ball_x(ball_x), .ball_y(ball_y), .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
    .score_l(score_l), .score_r(score_r), .state(state), .game_over(game_over)
  );

  function automatic logic [50:0] dut_vec();
    return {state, game_over, ball_x, ball_y, pad_l_y, pad_r_y, score_l, score_r};
  endfunction

  function automatic logic [50:0] mdl_vec();
    return {2'(m_state), (m_state == 3), 10'(m_bx), 10'(m_by), 10'(m_pl), 10'(m_pr), 4'(m_sl), 4'(m_sr)};
  endfunction

  task automatic mdl_reset();
    m_state = 0; m_bx = BX0; m_by = BY0; m_vx = 0; m_vy = 0;
    m_pl = PY0; m_pr = PY0; m_sl = 0; m_sr = 0; m_serve_ticks = 0; m_dir = 1; m_sp = 1'b0;
  endtask

  function automatic int pad_after(input int y, input bit up, input bit dn);
    if (up && !dn) return (y - PSTEP < 0) ? 0 : y - PSTEP;
    if (dn && !up) return (y + PSTEP > VA - PH) ? VA - PH : y + PSTEP;
    return y;
  endfunction

  task automatic move_pads(input bit lu, input bit ld, input bit ru, input bit rd);
    int d;
    m_pl = pad_after(m_pl, lu, ld);
`ifdef PONG_AI_EN
    d = (m_by + BS / 2) - (m_pr + PH / 2);
    m_pr = pad_after(m_pr, d <= -PSTEP, d >= PSTEP);
    if (ru || rd) d = 0;
`else
    d = 0;
    m_pr = pad_after(m_pr, ru, rd);
`endif
  endtask

  task automatic ball_tick(input int pl, input int pr);
    int nx, ny;
    bit hl, hr;
    nx = m_bx + m_vx;
    ny = m_by + m_vy;
    if (ny <= 0) begin ny = 0; m_vy = BSTEP; n_wall++; end
    else if (ny >= VA - BS) begin ny = VA - BS; m_vy = -BSTEP; n_wall++; end
    hl = (m_vx < 0) && (nx <= XL_FACE) && (m_bx >= XL_FACE) && (m_by + BS > pl) && (m_by < pl + PH);
    hr = (m_vx > 0) && (nx >= XR_FACE) && (m_bx <= XR_FACE) && (m_by + BS > pr) && (m_by < pr + PH);
    if (hl) begin nx = XL_FACE; m_vx = BSTEP; n_hits++; end
    else if (hr) begin nx = XR_FACE; m_vx = -BSTEP; n_hits++; end
    else if (nx <= 0 || nx >= HA - BS) begin
      if (nx <= 0) begin m_sr++; m_dir = -1; end
      else begin m_sl++; m_dir = 1; end
      n_miss++;
      m_state = (m_sl == WIN || m_sr == WIN) ? 3 : 1;
      m_serve_ticks = 0;
      nx = BX0; ny = BY0; m_vx = 0; m_vy = 0;
    end
    m_bx = nx;
    m_by = ny;
  endtask

  task automatic mdl_clock(input bit rst_i, input bit tick_i, input bit start_i,
                           input bit lu, input bit ld, input bit ru, input bit rd);
    bit rise;
    int opl, opr;
    if (!rst_i) begin
      mdl_reset();
      return;
    end
    rise = start_i && !m_sp;
    m_sp = start_i;
    if (rise && (m_state == 0 || m_state == 3)) begin
      m_state = 1; m_sl = 0; m_sr = 0; m_dir = 1; m_serve_ticks = 0;
    end else if (tick_i && m_state == 1) begin
      move_pads(lu, ld, ru, rd);
      m_serve_ticks++;
      if (m_serve_ticks == SERVE_N) begin
        m_state = 2; m_vx = BSTEP * m_dir; m_vy = BSTEP;
      end
    end else if (tick_i && m_state == 2) begin
      opl = m_pl; opr = m_pr;
      move_pads(lu, ld, ru, rd);
      ball_tick(opl, opr);
    end
  endtask

  // Drive one clock cycle (inputs on the falling edge), advance the model, return just after the rising edge.
  task automatic step(input bit rst_i, input bit tick_i, input bit start_i,
                      input bit lu, input bit ld, input bit ru, input bit rd);
    @(negedge clk);
    reset_n = rst_i; start = start_i;
    btn_l_up = lu; btn_l_dn = ld; btn_r_up = ru; btn_r_dn = rd;
    if (tick_i) begin
      hcount = 10'd0; vcount = 10'(VA);
    end else begin
      case ($urandom_range(2))
        0:       begin hcount = 10'd0; vcount = 10'($urandom_range(1023)); end
        1:       begin hcount = 10'($urandom_range(1023)); vcount = 10'(VA); end
        default: begin hcount = 10'($urandom_range(1023)); vcount = 10'($urandom_range(1023)); end
      endcase
      if (hcount == 10'd0 && vcount == 10'(VA)) vcount = 10'(VA + 1);
    end
    mdl_clock(rst_i, tick_i, start_i, lu, ld, ru, rd);
    @(posedge clk);
    #1;
  endtask

  task automatic pick_btns(input int mode, input int pad, output bit up, output bit dn);
    int d;
    up = 1'b0; dn = 1'b0;
    case (mode)
      M_RAND:  begin up = 1'($urandom_range(1)); dn = 1'($urandom_range(1)); end
      M_SMART: begin
        d = (m_by + BS / 2) - (pad + PH / 2);
        if (d >= PSTEP) dn = 1'b1;
        else if (d <= -PSTEP) up = 1'b1;
      end
      M_UP:    up = 1'b1;
      M_BOTH:  begin up = 1'b1; dn = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (dut_vec() !== RST_VEC) begin
      errors++; $display("FAIL reset_values: got %h expected %h", dut_vec(), RST_VEC);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i[0], 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL idle_hold %0d: got %h expected %h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_serve();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (state !== 2'd1) begin
      errors++; $display("FAIL start_edge_state: got %0d expected 1", state);
    end
    for (int t = 1; t <= SERVE_N + 1; t++) begin
      for (int f = 0; f < 2; f++) begin
        step(1'b1, f == 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dut_vec() !== mdl_vec()) begin
          errors++; $display("FAIL serve t%0d f%0d: got %h expected %h", t, f, dut_vec(), mdl_vec());
        end
      end
      if (t <= SERVE_N) begin
        checks++;
        if (state !== ((t < SERVE_N) ? 2'd1 : 2'd2)) begin
          errors++; $display("FAIL serve_len tick %0d: state %0d expected %0d", t, state, (t < SERVE_N) ? 1 : 2);
        end
      end
    end
    checks++;
    if (ball_x !== 10'd318 || ball_y !== 10'd238) begin
      errors++; $display("FAIL first_move: got (%0d,%0d) expected (318,238)", ball_x, ball_y);
    end
    // start edges during play, one of them on a tick
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i == 3, i[0], 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (state !== 2'd2 || dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL start_in_play %0d: got %h expected %h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_buttons();
    for (int t = 0; t < 60; t++) begin
      for (int f = 0; f < 2; f++) begin
        step(1'b1, f == 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (dut_vec() !== mdl_vec()) begin
          errors++; $display("FAIL buttons t%0d: got %h expected %h", t, dut_vec(), mdl_vec());
        end
      end
    end
    checks++;
    if (pad_l_y !== 10'd0) begin
      errors++; $display("FAIL pad_up_saturate: got %0d expected 0", pad_l_y);
    end
`ifndef PONG_AI_EN
    checks++;
    if (pad_r_y !== 10'd208) begin
      errors++; $display("FAIL pad_both_hold: got %0d expected 208", pad_r_y);
    end
`endif
  endtask

  task automatic test_left_miss();
    bit lu, ld, ru, rd;
    int t;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (t = 0; t < 2000 && score_r === 4'd0; t++) begin
      pick_btns(M_UP, m_pl, lu, ld);
      pick_btns(M_SMART, m_pr, ru, rd);
      for (int f = 0; f < 2; f++) begin
        step(1'b1, f == 1, 1'b1, lu, ld, ru, rd);
        checks++;
        if (dut_vec() !== mdl_vec()) begin
          errors++; $display("FAIL left_miss t%0d: got %h expected %h", t, dut_vec(), mdl_vec());
        end
      end
    end
    checks++;
    if (score_r !== 4'd1 || score_l !== 4'd0 || state !== 2'd1) begin
      errors++; $display("FAIL left_miss_score: score_r=%0d score_l=%0d state=%0d expected 1,0,1", score_r, score_l, state);
    end
  endtask

  task automatic test_game_over();
    bit lu, ld, ru, rd;
`ifdef PONG_AI_EN
    localparam int LM = M_NONE;
`else
    localparam int LM = M_SMART;
`endif
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 6000 && state !== 2'd3; t++) begin
      pick_btns(LM, m_pl, lu, ld);
      pick_btns(M_NONE, m_pr, ru, rd);
      for (int f = 0; f < 2; f++) begin
        step(1'b1, f == 1, 1'b1, lu, ld, ru, rd);
        checks++;
        if (dut_vec() !== mdl_vec()) begin
          errors++; $display("FAIL game t%0d: got %h expected %h", t, dut_vec(), mdl_vec());
        end
      end
    end
    checks++;
`ifdef PONG_AI_EN
    if (state !== 2'd3 || game_over !== 1'b1 || score_r !== 4'd9) begin
`else
    if (state !== 2'd3 || game_over !== 1'b1 || score_l !== 4'd9) begin
`endif
      errors++; $display("FAIL game_over: state=%0d go=%0d scores=%0d/%0d expected 3,1,winner 9", state, game_over, score_l, score_r);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 5; t++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL over_frozen t%0d: got %h expected %h", t, dut_vec(), mdl_vec());
      end
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (state !== 2'd1 || score_l !== 4'd0 || score_r !== 4'd0 || game_over !== 1'b0) begin
      errors++; $display("FAIL restart: state=%0d scores=%0d/%0d go=%0d expected 1,0/0,0", state, score_l, score_r, game_over);
    end
  endtask

  task automatic test_random_play();
    bit lu, ld, ru, rd, st;
    int ml, mr, nf;
    st = 1'b0;
    ml = M_SMART; mr = M_RAND;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 5000; t++) begin
      if ($urandom_range(150) == 0) begin
        ml = $urandom_range(2); mr = $urandom_range(2);
      end
      pick_btns(ml, m_pl, lu, ld);
      pick_btns(mr, m_pr, ru, rd);
      nf = $urandom_range(2);
      for (int f = 0; f <= nf; f++) begin
        if ($urandom_range(40) == 0) st = ~st;
        step(1'b1, f == nf, st, lu, ld, ru, rd);
        checks++;
        if (dut_vec() !== mdl_vec()) begin
          errors++; $display("FAIL random t%0d f%0d: got %h expected %h", t, f, dut_vec(), mdl_vec());
        end
      end
    end
  endtask

  task automatic test_reset_midgame();
    bit lu, ld, ru, rd;
    int extra;
    for (int r = 0; r < 3; r++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      extra = SERVE_N + 1 + $urandom_range(120);
      for (int t = 0; t < extra; t++) begin
        pick_btns(M_RAND, m_pl, lu, ld);
        pick_btns(M_SMART, m_pr, ru, rd);
        step(1'b1, 1'b0, 1'b0, lu, ld, ru, rd);
        step(1'b1, 1'b1, 1'b0, lu, ld, ru, rd);
        checks++;
        if (dut_vec() !== mdl_vec()) begin
          errors++; $display("FAIL pre_reset r%0d t%0d: got %h expected %h", r, t, dut_vec(), mdl_vec());
        end
      end
      for (int f = 0; f < r; f++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // reset lands together with a tick and a start edge
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if (dut_vec() !== RST_VEC) begin
        errors++; $display("FAIL reset_midgame r%0d: got %h expected %h", r, dut_vec(), RST_VEC);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; hcount = 10'd1; vcount = 10'd0;
    btn_l_up = 1'b0; btn_l_dn = 1'b0; btn_r_up = 1'b0; btn_r_dn = 1'b0;
    mdl_reset();
    test_reset();
    test_serve();
    test_buttons();
    test_left_miss();
    test_game_over();
    test_random_play();
    test_reset_midgame();
    $display("model events: hits=%0d misses=%0d walls=%0d", n_hits, n_miss, n_wall);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_ctrl.md
# pong_ctrl

Game controller for the pong design: it sequences ball motion, paddle motion, collision, scoring and serve timing, and advances once per video frame. It sits between the VGA timing counters (`hcount`/`vcount`) and the `frame` renderer, and supplies registered object positions and scores. Because state updates only at the start of vertical blanking, positions are stable for the whole active picture.

## Interface
- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines.
- `BALL_SIZE`, 8: ball edge, pixels.
- `PADDLE_W`, 8 / `PADDLE_H`, 64: paddle size, pixels.
- `PADDLE_XL`, 16 / `PADDLE_XR`, 616: left x of left / right paddle.
- `PADDLE_STEP`, 4: paddle pixels per frame.
- `BALL_STEP`, 2: ball pixels per frame per axis.
- `SERVE_FRAMES`, 60: frames ball is held before launch.
- `WIN_SCORE`, 9: score that ends the game (≤15).

Ports:
- `clk` in 1: pixel clock, the same domain as the vga block.
- `reset_n` in 1: synchronous, active-low reset.
- `hcount` in 10: current pixel column.
- `vcount` in 10: current line.
- `start` in 1: level; its rising edge is detected internally.
- `btn_l_up`, `btn_l_dn`, `btn_r_up`, `btn_r_dn` in 1 each: active-high, already synchronized to `clk`.
- `ball_x`, `ball_y` out 10: ball top-left corner.
- `pad_l_y`, `pad_r_y` out 10: paddle top edges.
- `score_l`, `score_r` out 4.
- `state` out 2: IDLE=0, SERVE=1, PLAY=2, OVER=3.
- `game_over` out 1: high while in OVER.

## Operation
- **Frame tick:** one-cycle internal pulse when `hcount==0 && vcount==V_ACTIVE`. All game state changes only on the cycle after a tick. Start-edge handling is the only exception.
- **IDLE:**
  - Ball is centred at (316, 236). Paddles are centred at 208. Scores are 0.
  - A `start` rising edge clears the scores, sets serve direction to +x, and moves to SERVE.
- **SERVE:**
  - Ball is held at the centre. The serve counter loads `SERVE_FRAMES` on entry and decrements each tick.
  - On the tick where the counter reaches 0, go to PLAY with vx = ±`BALL_STEP` (serve direction) and vy = +`BALL_STEP`.
  - Paddles move during SERVE.
- **PLAY,** on each tick:
  - Compute next = ball + v in 11-bit signed arithmetic.
  - Top wall: next_y ≤ 0 → y=0, vy=+.
  - Bottom wall: next_y ≥ `V_ACTIVE-BALL_SIZE` → clamp to that value, vy=−.
  - Left paddle hit requires all of:
    - vx<0;
    - next_x ≤ `PADDLE_XL+PADDLE_W`;
    - current ball_x ≥ `PADDLE_XL+PADDLE_W`;
    - ball_y+`BALL_SIZE` > pad_l_y and ball_y < pad_l_y+`PADDLE_H`.
    
    On a hit: x=`PADDLE_XL+PADDLE_W`, vx=+.
  - Right paddle hit mirrors this at `PADDLE_XR-BALL_SIZE` with vx>0. On a hit, vx=−.
  - Wall and paddle bounces on the same tick are both applied.
  - Miss: next_x ≤ 0 → `score_r`+1 and serve direction −x. next_x ≥ `H_ACTIVE-BALL_SIZE` → `score_l`+1 and serve direction +x. The ball is served toward the player who conceded.
  - After a miss: if the new score equals `WIN_SCORE` → OVER, else → SERVE.
- **OVER:**
  - Ball is frozen and scores are held.
  - A `start` rising edge clears the scores and enters SERVE with direction +x.
- **Paddles (SERVE/PLAY):**
  - Up button: y −= `PADDLE_STEP`, saturating at 0.
  - Down button: y += step, saturating at `V_ACTIVE-PADDLE_H`.
  - Both pressed or neither pressed: hold.
- `start` edges during SERVE or PLAY are ignored.

## Timing
- All outputs are registered. Positions and scores change exactly one `clk` after the frame tick and are constant otherwise.
- A `start` edge is acted on one cycle after the edge, with no wait for a tick.
- SERVE lasts exactly `SERVE_FRAMES` ticks. The first ball movement occurs on the tick after entry to PLAY.
- Reset values:
  - `state`=IDLE, `game_over`=0;
  - `ball_x`=316, `ball_y`=236;
  - `pad_l_y`=`pad_r_y`=208;
  - scores 0, velocities 0;
  - start-edge register cleared.
- Reset asserted mid-game returns to IDLE on the next `clk` edge, regardless of pending tick or edge.
- Score increment and the transition to OVER occur on the same cycle.

## Configuration
- `PONG_AI_EN` defined:
  - The right paddle ignores `btn_r_up`/`btn_r_dn`.
  - Each tick it moves `PADDLE_STEP` toward alignment of its centre with the ball centre.
  - It holds when the centres differ by less than `PADDLE_STEP`, and keeps the same saturation limits.
- `PONG_AI_EN` undefined: the right paddle is button-driven, identical to the left.

## Test plan
- Reset, pulse `start`, run 60 ticks → `state`=1 for 60 ticks, then 2. Ball moves to (318, 238) one cycle after the next tick.
- Ball placed near the top (y=1, vy=−2) → after the tick, y=0 and vy=+2. At the bottom, y clamps to 472.
- Left paddle at 208, ball at x=24, y=230, vx=−2 → after the tick, x=24 and vx=+2. With the paddle at 0, the ball proceeds to x≤0, `score_r`=1, `state`=1.
- `score_l`=8 and the ball crosses the right edge → `score_l`=9, `state`=3, `game_over`=1. `start` → scores 0, `state`=1.
- Hold `btn_l_up` for 60 ticks from 208 → `pad_l_y` reaches 0 and stays there. Both buttons held → no change.
- `reset_n`=0 during PLAY at an arbitrary cycle → all outputs equal their reset values on the next cycle. With `PONG_AI_EN`, the right paddle tracks the ball to within 4 pixels.
